// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for ARM LDM/STM: walks the register list lowest index first,
// issuing one word beat per accepted cycle, then pulses Done and the optional base write-back.
module ldm_stm_sequencer #(
    parameter int LIST_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(LIST_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_isLoad,
    input  logic                  i_up,
    input  logic                  i_preIndex,
    input  logic                  i_writeBack,
    input  logic [LIST_WIDTH-1:0] i_regList,
    input  logic [ADDR_WIDTH-1:0] i_baseAddr,
    input  logic                  i_memReady,
    output logic                  o_busy,
    output logic                  o_memValid,
    output logic                  o_memWrite,
    output logic [ADDR_WIDTH-1:0] o_memAddr,
    output logic [IDX_WIDTH-1:0]  o_regNum,
    output logic                  o_done,
    output logic                  o_wbValid,
    output logic [ADDR_WIDTH-1:0] o_wbData
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [LIST_WIDTH-1:0] r_list;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [ADDR_WIDTH-1:0] r_wbData;
    logic                  r_isLoad;
    logic                  r_wbEn;

    logic [IDX_WIDTH-1:0]  w_findIdx;
    logic [LIST_WIDTH-1:0] w_listCleared;
    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_firstAddr;
    logic [ADDR_WIDTH-1:0] w_wbNext;
    logic                  w_accept;

    function automatic logic [ADDR_WIDTH-1:0] popcount(input logic [LIST_WIDTH-1:0] list);
        logic [ADDR_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LIST_WIDTH; i++) begin
            cnt = cnt + ADDR_WIDTH'(list[i]);
        end
        return cnt;
    endfunction

    // Block span in bytes (4N); every mode lays the block out at ascending addresses.
    assign w_bytes  = popcount(i_regList) << 2;
    assign w_wbNext = i_up ? (i_baseAddr + w_bytes) : (i_baseAddr - w_bytes);

    always_comb begin
        w_firstAddr = i_baseAddr;
        case ({i_up, i_preIndex})
            2'b10:   w_firstAddr = i_baseAddr;
            2'b11:   w_firstAddr = i_baseAddr + ADDR_WIDTH'(4);
            2'b00:   w_firstAddr = i_baseAddr - w_bytes + ADDR_WIDTH'(4);
            default: w_firstAddr = i_baseAddr - w_bytes;
        endcase
    end

    // FindOne: scan high to low so the lowest set bit is the last one written.
    always_comb begin
        w_findIdx = '0;
        for (int i = LIST_WIDTH - 1; i >= 0; i--) begin
            if (r_list[i]) begin
                w_findIdx = IDX_WIDTH'(i);
            end
        end
    end

    assign w_listCleared = r_list & (r_list - LIST_WIDTH'(1));
    assign w_accept      = (r_state == XFER) && i_memReady;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = (|i_regList) ? XFER : DONE;
                end
            end
            XFER: begin
                if (w_accept && (w_listCleared == '0)) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_list    <= '0;
            r_memAddr <= '0;
            r_wbData  <= '0;
            r_isLoad  <= 1'b0;
            r_wbEn    <= 1'b0;
        end else if ((r_state == IDLE) && i_start) begin
            r_list    <= i_regList;
            r_memAddr <= w_firstAddr;
            r_wbData  <= w_wbNext;
            r_isLoad  <= i_isLoad;
            r_wbEn    <= i_writeBack && (|i_regList);
        end else if (w_accept) begin
            r_list    <= w_listCleared;
            r_memAddr <= r_memAddr + ADDR_WIDTH'(4);
        end
    end

    // Every output decodes from registered state only, so Start never reaches them combinationally.
    assign o_busy     = (r_state != IDLE);
    assign o_memValid = (r_state == XFER);
    assign o_memWrite = o_memValid && !r_isLoad;
    assign o_memAddr  = r_memAddr;
    assign o_regNum   = w_findIdx;
    assign o_done     = (r_state == DONE);
    assign o_wbValid  = o_done && r_wbEn;
    assign o_wbData   = r_wbData;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: each task drives one scenario and
// compares the outputs against hand-computed beats and write-back values.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        isLoad;
    logic        up;
    logic        preIndex;
    logic        writeBack;
    logic [15:0] regList;
    logic [31:0] baseAddr;
    logic        memReady;
    logic        busy;
    logic        memValid;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [3:0]  regNum;
    logic        done;
    logic        wbValid;
    logic [31:0] wbData;

    int testsRun    = 0;
    int testsFailed = 0;

    ldm_stm_sequencer #(
        .LIST_WIDTH(16),
        .ADDR_WIDTH(32)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_isLoad   (isLoad),
        .i_up       (up),
        .i_preIndex (preIndex),
        .i_writeBack(writeBack),
        .i_regList  (regList),
        .i_baseAddr (baseAddr),
        .i_memReady (memReady),
        .o_busy     (busy),
        .o_memValid (memValid),
        .o_memWrite (memWrite),
        .o_memAddr  (memAddr),
        .o_regNum   (regNum),
        .o_done     (done),
        .o_wbValid  (wbValid),
        .o_wbData   (wbData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startXfer(input logic load, input logic u, input logic p, input logic w,
                             input logic [15:0] list, input logic [31:0] base);
        isLoad    = load;
        up        = u;
        preIndex  = p;
        writeBack = w;
        regList   = list;
        baseAddr  = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        testsRun++;
        if ({busy, memValid, memWrite, done, wbValid} !== 5'b0 || regNum !== 4'd0 ||
            memAddr !== 32'h0 || wbData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got flags=%b reg=%0d addr=%h wb=%h, expected all 0",
                     {busy, memValid, memWrite, done, wbValid}, regNum, memAddr, wbData);
        end
    endtask

    task automatic test_stm_ia();
        logic [3:0]  expReg [3];
        logic [31:0] expAddr[3];
        expReg[0] = 4'd0; expAddr[0] = 32'h100;
        expReg[1] = 4'd1; expAddr[1] = 32'h104;
        expReg[2] = 4'd3; expAddr[2] = 32'h108;
        memReady = 1'b1;
        startXfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h000B, 32'h100);
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (memValid !== 1'b1 || memWrite !== 1'b1 || busy !== 1'b1 ||
                regNum !== expReg[i] || memAddr !== expAddr[i]) begin
                testsFailed++;
                $display("[TB] FAIL stm_ia_beat%0d: got valid=%b wr=%b reg=%0d addr=%h, expected valid=1 wr=1 reg=%0d addr=%h",
                         i, memValid, memWrite, regNum, memAddr, expReg[i], expAddr[i]);
            end
            tick();
        end
        testsRun++;
        if (done !== 1'b1 || wbValid !== 1'b1 || wbData !== 32'h10C || memValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stm_ia_done: got done=%b wbv=%b wb=%h valid=%b, expected 1 1 0000010c 0",
                     done, wbValid, wbData, memValid);
        end
        tick();
        testsRun++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stm_ia_idle: got done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_ldm_db();
        logic [3:0]  expReg [2];
        logic [31:0] expAddr[2];
        expReg[0] = 4'd0;  expAddr[0] = 32'h1F8;
        expReg[1] = 4'd15; expAddr[1] = 32'h1FC;
        memReady = 1'b1;
        startXfer(1'b1, 1'b0, 1'b1, 1'b1, 16'h8001, 32'h200);
        for (int i = 0; i < 2; i++) begin
            testsRun++;
            if (memValid !== 1'b1 || memWrite !== 1'b0 ||
                regNum !== expReg[i] || memAddr !== expAddr[i]) begin
                testsFailed++;
                $display("[TB] FAIL ldm_db_beat%0d: got valid=%b wr=%b reg=%0d addr=%h, expected valid=1 wr=0 reg=%0d addr=%h",
                         i, memValid, memWrite, regNum, memAddr, expReg[i], expAddr[i]);
            end
            tick();
        end
        testsRun++;
        if (done !== 1'b1 || wbValid !== 1'b1 || wbData !== 32'h1F8) begin
            testsFailed++;
            $display("[TB] FAIL ldm_db_done: got done=%b wbv=%b wb=%h, expected 1 1 000001f8",
                     done, wbValid, wbData);
        end
        tick();
    endtask

    task automatic test_ib_stall();
        memReady = 1'b0;
        startXfer(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h40);
        for (int c = 0; c < 4; c++) begin
            testsRun++;
            if (memValid !== 1'b1 || busy !== 1'b1 || regNum !== 4'd4 || memAddr !== 32'h44) begin
                testsFailed++;
                $display("[TB] FAIL ib_hold_cycle%0d: got valid=%b busy=%b reg=%0d addr=%h, expected valid=1 busy=1 reg=4 addr=00000044",
                         c, memValid, busy, regNum, memAddr);
            end
            if (c == 3) memReady = 1'b1;
            tick();
        end
        testsRun++;
        if (done !== 1'b1 || memValid !== 1'b0 || wbValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ib_done: got done=%b valid=%b wbv=%b, expected 1 0 0",
                     done, memValid, wbValid);
        end
        tick();
    endtask

    task automatic test_empty_list();
        memReady = 1'b1;
        startXfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h500);
        testsRun++;
        if (done !== 1'b1 || memValid !== 1'b0 || wbValid !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL empty_done: got done=%b valid=%b wbv=%b busy=%b, expected 1 0 0 1",
                     done, memValid, wbValid, busy);
        end
        tick();
        testsRun++;
        if (done !== 1'b0 || busy !== 1'b0 || memValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL empty_idle: got done=%b busy=%b valid=%b, expected 0 0 0",
                     done, busy, memValid);
        end
    endtask

    task automatic test_reset_abort();
        memReady = 1'b1;
        startXfer(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h1000);
        tick();
        tick();
        testsRun++;
        if (memValid !== 1'b1 || regNum !== 4'd2 || memAddr !== 32'h1008) begin
            testsFailed++;
            $display("[TB] FAIL abort_beat2: got valid=%b reg=%0d addr=%h, expected 1 2 00001008",
                     memValid, regNum, memAddr);
        end
        #1 rst = 1'b1;
        #1;
        testsRun++;
        if ({busy, memValid, memWrite, done, wbValid} !== 5'b0 || regNum !== 4'd0 ||
            memAddr !== 32'h0 || wbData !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL abort_async_clear: got flags=%b reg=%0d addr=%h wb=%h, expected all 0",
                     {busy, memValid, memWrite, done, wbValid}, regNum, memAddr, wbData);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            testsRun++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL abort_no_done%0d: got done=%b busy=%b, expected 0 0", c, done, busy);
            end
        end
        startXfer(1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h300);
        testsRun++;
        if (memValid !== 1'b1 || memWrite !== 1'b0 || regNum !== 4'd0 || memAddr !== 32'h300) begin
            testsFailed++;
            $display("[TB] FAIL restart_beat: got valid=%b wr=%b reg=%0d addr=%h, expected 1 0 0 00000300",
                     memValid, memWrite, regNum, memAddr);
        end
        tick();
        testsRun++;
        if (done !== 1'b1 || wbValid !== 1'b1 || wbData !== 32'h304) begin
            testsFailed++;
            $display("[TB] FAIL restart_done: got done=%b wbv=%b wb=%h, expected 1 1 00000304",
                     done, wbValid, wbData);
        end
        tick();
    endtask

    task automatic test_start_ignored_da_wrap();
        memReady = 1'b1;
        startXfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 32'h0);
        testsRun++;
        if (memValid !== 1'b1 || regNum !== 4'd0 || memAddr !== 32'hFFFF_FFFC) begin
            testsFailed++;
            $display("[TB] FAIL da_beat0: got valid=%b reg=%0d addr=%h, expected 1 0 fffffffc",
                     memValid, regNum, memAddr);
        end
        startXfer(1'b1, 1'b1, 1'b1, 1'b0, 16'h00F0, 32'h7000);
        testsRun++;
        if (memValid !== 1'b1 || memWrite !== 1'b1 || regNum !== 4'd1 || memAddr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL da_beat1: got valid=%b wr=%b reg=%0d addr=%h, expected 1 1 1 00000000",
                     memValid, memWrite, regNum, memAddr);
        end
        tick();
        testsRun++;
        if (done !== 1'b1 || wbValid !== 1'b1 || wbData !== 32'hFFFF_FFF8) begin
            testsFailed++;
            $display("[TB] FAIL da_done: got done=%b wbv=%b wb=%h, expected 1 1 fffffff8",
                     done, wbValid, wbData);
        end
        startXfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h900);
        testsRun++;
        if (busy !== 1'b0 || memValid !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL done_start_not_queued: got busy=%b valid=%b done=%b, expected 0 0 0",
                     busy, memValid, done);
        end
        tick();
        testsRun++;
        if (busy !== 1'b0 || memValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_stays_idle: got busy=%b valid=%b, expected 0 0", busy, memValid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        isLoad    = 1'b0;
        up        = 1'b0;
        preIndex  = 1'b0;
        writeBack = 1'b0;
        regList   = 16'h0;
        baseAddr  = 32'h0;
        memReady  = 1'b0;
        #3;
        test_reset();
        #10 rst = 1'b0;
        tick();
        test_stm_ia();
        test_ldm_db();
        test_ib_stall();
        test_empty_list();
        test_reset_abort();
        test_start_ignored_da_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter LIST_WIDTH, default 16: register-list width, one bit per architectural register.
REQ-002 Parameter ADDR_WIDTH, default 32: memory address and base-register width.
REQ-003 Parameter IDX_WIDTH, default $clog2(LIST_WIDTH): register-index width.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-007 IsLoad  input  1  1 = LDM (memory to register), 0 = STM.
REQ-008 Up  input  1  ARM U bit: 1 = increment, 0 = decrement.
REQ-009 PreIndex  input  1  ARM P bit: 1 = before, 0 = after.
REQ-010 WriteBack  input  1  ARM W bit: request base-register update.
REQ-011 RegList  input  LIST_WIDTH  register list; bit i set = transfer Ri.
REQ-012 BaseAddr  input  ADDR_WIDTH  base register value.
REQ-013 MemReady  input  1  memory accepts the current beat this cycle.
REQ-014 Busy  output  1  high in XFER and DONE; drives pipeline stall.
REQ-015 MemValid  output  1  a beat is presented on MemAddr/RegNum.
REQ-016 MemWrite  output  1  copy of latched ~IsLoad, qualified by MemValid.
REQ-017 MemAddr  output  ADDR_WIDTH  word address of the current beat.
REQ-018 RegNum  output  IDX_WIDTH  register index of the current beat.
REQ-019 Done  output  1  one-cycle pulse on completion.
REQ-020 WBValid  output  1  one-cycle pulse with Done when the latched WriteBack = 1.
REQ-021 WBData  output  ADDR_WIDTH  new base value; valid while WBValid = 1.

Function
REQ-022 States SHALL be IDLE, XFER and DONE, held in a registered state machine.
REQ-023 In IDLE with Start = 1, the block SHALL latch RegList, IsLoad, WriteBack and the computed addresses, then enter XFER if RegList != 0, else DONE.
REQ-024 N SHALL be the popcount of the latched list; address arithmetic SHALL be modulo 2^ADDR_WIDTH.
REQ-025 The first beat address SHALL be:
- IA: Base
- IB: Base+4
- DA: Base-4N+4
- DB: Base-4N
REQ-026 WBData SHALL be Base+4N when Up = 1 and Base-4N when Up = 0.
REQ-027 In XFER, MemValid SHALL be 1.
REQ-028 In XFER, RegNum SHALL equal the index of the lowest set bit of the remaining list, produced by an internal FindOne priority encoder.
REQ-029 On a cycle with MemValid & MemReady, the block SHALL clear that bit and add 4 to MemAddr; otherwise all beat outputs SHALL hold stable.
REQ-030 When the accepted beat clears the last set bit, the next state SHALL be DONE and MemValid SHALL drop in the same edge.
REQ-031 DONE SHALL last exactly one cycle: Done = 1, WBValid = latched WriteBack and RegList != 0, then IDLE.
REQ-032 Latency: Start at edge k gives first MemValid in cycle k+1; with MemReady held high, Done is asserted in cycle k+N+1.
REQ-033 Start SHALL be ignored in XFER and DONE; a Start in the DONE cycle SHALL NOT be queued.
REQ-034 An empty RegList SHALL produce no beats, Done one cycle after Start, and WBValid = 0.
REQ-035 Registers SHALL be issued in ascending index order at ascending addresses, for all four P/U modes.
REQ-036 All outputs SHALL be registered; there SHALL be no combinational path from Start to the outputs.

Reset
REQ-037 Reset SHALL force IDLE and clear the remaining list and MemAddr asynchronously, independent of CLK.
REQ-038 While in reset, Busy, MemValid, MemWrite, Done, WBValid, RegNum, MemAddr and WBData SHALL all be 0.
REQ-039 Reset asserted mid-XFER SHALL abort the transfer with no Done pulse; after release the block SHALL accept a new Start.

Verification
REQ-040 STM IA, W=1, Base=0x100, RegList=0x000B, MemReady=1 -> beats (R0,0x100), (R1,0x104), (R3,0x108), then Done with WBData=0x10C.
REQ-041 LDM DB, W=1, Base=0x200, RegList=0x8001 -> beats (R0,0x1F8), (R15,0x1FC), MemWrite=0, WBData=0x1F8.
REQ-042 IB, Base=0x40, RegList=0x0010, MemReady low 3 cycles then high -> MemAddr=0x44 and RegNum=4 held 4 cycles; Done the cycle after acceptance.
REQ-043 RegList=0x0000, W=1 -> no MemValid, Done one cycle after Start, WBValid=0.
REQ-044 Reset pulse after the 2nd beat of RegList=0xFFFF -> all outputs 0 immediately, no Done; a fresh Start with 0x0001 completes normally.
REQ-045 Start pulsed during XFER, and DA with Base=0x0 and RegList=0x0003 -> the extra Start is ignored; the DA case wraps to beats 0xFFFFFFFC and 0x00000000, WBData=0xFFFFFFF8.
